// File: rtl/adler32_arbiter.sv
// Round-robin arbiter that lends one adler32 engine to two byte-stream requesters for one frame at a time.
// Bytes are forwarded one cycle after acceptance; the checksum or a timeout ends the frame, and only the owner sees rdy.
module adler32_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        vld0,
  input  logic        vld1,
  input  logic [7:0]  byte0,
  input  logic [7:0]  byte1,
  input  logic        last0,
  input  logic        last1,
  output logic        rdy0,
  output logic        rdy1,
  output logic        eng_rst_n,
  output logic        eng_data_valid,
  output logic [7:0]  eng_data,
  output logic        eng_last_data,
  input  logic        eng_checksum_valid,
  input  logic [31:0] eng_checksum,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] sum_out
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_STREAM, ST_WAIT} state_t;

  state_t        state_q;
  logic          owner_q;
  logic          last_grant_q;
  logic [1:0]    rdy_q;
  logic [1:0]    done_q;
  logic [1:0]    err_q;
  logic          eng_rst_n_q;
  logic          eng_data_valid_q;
  logic [7:0]    eng_data_q;
  logic          eng_last_data_q;
  logic [31:0]   sum_q;
  logic [TW-1:0] timer_q;

  logic          grant_d;
  logic          accept_d;
  logic [7:0]    own_byte_d;
  logic          own_last_d;

  // On a tie the requester that did not hold the engine last time wins.
  always_comb begin
    grant_d = req1;
    if (req0 && req1) begin
      grant_d = ~last_grant_q;
    end
    own_byte_d = owner_q ? byte1 : byte0;
    own_last_d = owner_q ? last1 : last0;
    accept_d   = (state_q == ST_STREAM) &&
                 (owner_q ? (vld1 && rdy_q[1]) : (vld0 && rdy_q[0]));
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      owner_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      rdy_q            <= 2'b00;
      done_q           <= 2'b00;
      err_q            <= 2'b00;
      eng_rst_n_q      <= 1'b0;
      eng_data_valid_q <= 1'b0;
      eng_data_q       <= 8'h00;
      eng_last_data_q  <= 1'b0;
      sum_q            <= 32'h0;
      timer_q          <= '0;
    end else begin
      done_q           <= 2'b00;
      err_q            <= 2'b00;
      eng_data_valid_q <= 1'b0;
      eng_last_data_q  <= 1'b0;
      eng_rst_n_q      <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (req0 || req1) begin
            owner_q      <= grant_d;
            last_grant_q <= grant_d;
            eng_rst_n_q  <= 1'b0;
            state_q      <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          rdy_q   <= owner_q ? 2'b10 : 2'b01;
          state_q <= ST_STREAM;
        end
        ST_STREAM: begin
          if (accept_d) begin
            eng_data_q       <= own_byte_d;
            eng_data_valid_q <= 1'b1;
            eng_last_data_q  <= own_last_d;
            if (own_last_d) begin
              rdy_q   <= 2'b00;
              timer_q <= '0;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A checksum arriving on the timeout cycle still counts as success.
          if (eng_checksum_valid) begin
            sum_q           <= eng_checksum;
            done_q[owner_q] <= 1'b1;
            state_q         <= ST_IDLE;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            err_q[owner_q] <= 1'b1;
            timer_q        <= TW'(TIMEOUT);
            state_q        <= ST_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdy0           = rdy_q[0];
  assign rdy1           = rdy_q[1];
  assign eng_rst_n      = eng_rst_n_q;
  assign eng_data_valid = eng_data_valid_q;
  assign eng_data       = eng_data_q;
  assign eng_last_data  = eng_last_data_q;
  assign done0          = done_q[0];
  assign done1          = done_q[1];
  assign err0           = err_q[0];
  assign err1           = err_q[1];
  assign sum_out        = sum_q;

endmodule

// File: doc/adler32_arbiter.md
ADLER32_ARBITER -- requirements
Module: adler32_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles to wait for eng_checksum_valid after the last byte is issued.
REQ-002 clock  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  requester N wants the engine for one frame.
REQ-005 vld0, vld1  input  1 each  requester N byte valid.
REQ-006 byte0, byte1  input  8 each  requester N data byte.
REQ-007 last0, last1  input  1 each  marks requester N's final byte of the frame.
REQ-008 rdy0, rdy1  output  1 each  byte accepted when vldN and rdyN are high on a clock edge.
REQ-009 eng_rst_n  output  1  registered active-low clear to the adler32 engine.
REQ-010 eng_data_valid, eng_data[7:0], eng_last_data  output  engine byte stream, registered.
REQ-011 eng_checksum_valid  input  1; eng_checksum  input  32  engine result.
REQ-012 done0, done1  output  1 each  one-cycle pulse: requester N's checksum is on sum_out.
REQ-013 err0, err1  output  1 each  one-cycle pulse: requester N's frame timed out.
REQ-014 sum_out  output  32  last captured checksum.

Function
REQ-015 FSM states IDLE, CLEAR, STREAM, WAIT, one-hot or encoded; exactly one active.
REQ-016 IDLE: if no req, stay; if one req, grant it; if both, grant the requester not granted last (round-robin); go to CLEAR.
REQ-017 The owner register holds the grant until the FSM returns to IDLE; req deassertion mid-frame does not end the frame.
REQ-018 CLEAR: eng_rst_n low for exactly one cycle, then STREAM.
REQ-019 STREAM: rdy of the owner high, rdy of the other low; non-owner inputs ignored.
REQ-020 Each accepted byte appears on eng_data with eng_data_valid=1 exactly one cycle later; eng_last_data mirrors lastN of that byte.
REQ-021 Cycles with owner vld low produce eng_data_valid=0; eng_data holds its prior value.
REQ-022 Accepted byte with last=1: rdy drops the next cycle; FSM goes to WAIT; timer cleared to 0.
REQ-023 WAIT: timer increments per cycle; eng_checksum_valid=1 -> sum_out<=eng_checksum, done of owner pulses same cycle as sum_out update, FSM to IDLE.
REQ-024 WAIT: timer reaching TIMEOUT with no eng_checksum_valid -> err of owner pulses one cycle, sum_out unchanged, FSM to IDLE.
REQ-025 eng_checksum_valid and timeout in the same cycle: checksum wins (done, not err).
REQ-026 eng_checksum_valid outside WAIT is ignored.
REQ-027 New grant may be issued in the IDLE cycle following done/err; minimum frame-to-frame gap is one IDLE cycle.
REQ-028 Timer width is ceil(log2(TIMEOUT+1)) bits and never wraps.

Reset
REQ-029 rst_n low asynchronously forces: FSM=IDLE, last-grant=requester1 (so requester0 wins first tie), rdy0/1=0, eng_rst_n=0, eng_data_valid=0, eng_data=0, eng_last_data=0, done0/1=0, err0/1=0, sum_out=0, timer=0.
REQ-030 eng_rst_n returns high on the first clock edge after rst_n deasserts.
REQ-031 Reset mid-STREAM or mid-WAIT aborts the frame with no done/err pulse.

Verification
REQ-032 req0 alone, byte 0x61 with last0 -> one CLEAR cycle, eng_data=0x61 with eng_last_data=1 one cycle after accept, engine returns 0x00620062 -> sum_out=0x00620062, done0 one pulse.
REQ-033 req0 and req1 asserted together after reset, each sending "abc" (0x61,0x62,0x63) -> requester0 served first, done0 with sum_out=0x024D0127, then requester1 done1 with 0x024D0127; rdy1 low throughout frame 0.
REQ-034 Back-to-back: both requesters hold req for three frames -> grants alternate 0,1,0,1,0,1.
REQ-035 Owner vld gaps (bytes on cycles 1,4,5) -> eng_data_valid high only one cycle after each accept, checksum unchanged vs gap-free stream.
REQ-036 Engine never asserts eng_checksum_valid -> err of owner pulses exactly TIMEOUT cycles after WAIT entry; sum_out unchanged; next request granted.
REQ-037 rst_n pulsed low in STREAM after 2 of 3 bytes -> all outputs at reset values immediately, no done/err, next frame after reset produces correct checksum.
